// File: rtl/arb_defs_pkg.sv
// rtl/arb_defs_pkg.sv - shared arbiter state encodings and default fairness constants
package arb_defs_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    VBURST = 1'b1
  } arb_state_e;

  // Shared with the video fetcher so its prefetch depth matches the burst grant.
  localparam int unsigned DEF_MAX_WAIT  = 8;
  localparam int unsigned DEF_BURST_LEN = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/video arbiter for the single synchronous memory port
module mem_port_arbiter
  import arb_defs_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);

  arb_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               cpu_rvalid_q, vid_rvalid_q;
  logic               cpu_gnt_c, vid_gnt_c;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    cpu_gnt_c   = 1'b0;
    vid_gnt_c   = 1'b0;
    case (state_q)
      ARB: begin
        if (vid_req && (wait_cnt_q == WAIT_MAX)) begin
          vid_gnt_c = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt_c = 1'b1;
        end else if (vid_req) begin
          vid_gnt_c = 1'b1;
        end
        if (vid_gnt_c) begin
          burst_cnt_d = BURST_LOAD;
          if (BURST_LEN > 1) state_d = VBURST;
        end
      end
      VBURST: begin
        // The burst ends early if video stops asking; the CPU gets the next slot.
        if (vid_req) begin
          vid_gnt_c   = 1'b1;
          burst_cnt_d = (burst_cnt_q == '0) ? '0 : burst_cnt_q - BURST_ONE;
          if (burst_cnt_q <= BURST_ONE) state_d = ARB;
        end else begin
          burst_cnt_d = '0;
          state_d     = ARB;
        end
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!vid_req || vid_gnt_c) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_ONE;
    end
  end

  // Grants drop the instant reset falls, even mid-cycle.
  assign cpu_gnt    = cpu_gnt_c & reset;
  assign vid_gnt    = vid_gnt_c & reset;

  assign mem_addr   = vid_gnt ? vid_addr : cpu_addr;
  assign mem_we     = cpu_gnt & cpu_we;
  assign mem_wdata  = cpu_wdata;
  assign rdata      = mem_rdata;
  assign cpu_rvalid = cpu_rvalid_q;
  assign vid_rvalid = vid_rvalid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      vid_rvalid_q <= vid_gnt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural model
module tb_mem_port_arbiter;
  import arb_defs_pkg::*;

  localparam int MW = DEF_MAX_WAIT;
  localparam int BL = DEF_BURST_LEN;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, vid_addr = '0;
  logic        cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  logic [15:0] ram [256];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  // Reference model: how long video has waited and how many grants it has taken in a row.
  logic [15:0] model_mem [256];
  int          waited = 0;
  int          streak = 0;
  logic        exp_crv = 1'b0, exp_vrv = 1'b0;
  logic [15:0] exp_rd = '0;
  logic        last_gc = 1'b0, last_gv = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    waited = 0; streak = 0; exp_crv = 1'b0; exp_vrv = 1'b0;
    last_gc = 1'b0; last_gv = 1'b0;
  endtask

  task automatic step(input logic rst, input logic cr, input logic cw,
                      input logic [15:0] ca, input logic [15:0] cd,
                      input logic vr, input logic [15:0] va);
    logic gc, gv;
    @(negedge clock);
    reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    vid_req = vr; vid_addr = va;
    #2;
    chk("cpu_rvalid", cpu_rvalid, rst & exp_crv);
    chk("vid_rvalid", vid_rvalid, rst & exp_vrv);
    if (rst && (exp_crv || exp_vrv)) chk("rdata", rdata, exp_rd);
    gc = 1'b0; gv = 1'b0;
    if (rst) begin
      if (streak > 0 && streak < BL) gv = vr;
      else if (vr && waited >= MW)   gv = 1'b1;
      else if (cr)                   gc = 1'b1;
      else if (vr)                   gv = 1'b1;
    end
    chk("cpu_gnt", cpu_gnt, gc);
    chk("vid_gnt", vid_gnt, gv);
    chk("mem_we", mem_we, gc & cw);
    chk("mem_addr", mem_addr, gv ? va : ca);
    chk("mem_wdata", mem_wdata, cd);
    if (!rst) begin
      model_reset();
    end else begin
      exp_crv = gc & ~cw;
      exp_vrv = gv;
      exp_rd  = gv ? model_mem[va[7:0]] : model_mem[ca[7:0]];
      if (gc && cw) model_mem[ca[7:0]] = cd;
      streak  = gv ? ((streak + 1 >= BL) ? 0 : streak + 1) : 0;
      waited  = (vr && !gv) ? ((waited + 1 > MW) ? MW : waited + 1) : 0;
      last_gc = gc; last_gv = gv;
    end
  endtask

  logic        hcr, hcw, hvr, rst_r;
  logic [15:0] hca, hcd, hva;

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 16'($urandom);
      ram[i] = model_mem[i];
    end
    model_mem[8'h10] = 16'hBEEF;
    ram[8'h10] = 16'hBEEF;

    // Reset held with both requesters active
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0100);
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0100);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_vid_gnt", vid_gnt, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0100);
    chk("release_cpu_first", cpu_gnt, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

    // CPU read returns 0xBEEF one cycle later
    step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
    chk("rd_mem_addr", mem_addr, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("rd_rvalid", cpu_rvalid, 1'b1);
    chk("rd_data", rdata, 16'hBEEF);

    // CPU write then readback
    step(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0);
    chk("wr_mem_we", mem_we, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("wr_no_rvalid", cpu_rvalid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("wr_readback", rdata, 16'h1234);

    // Both held: 8 CPU, 4 video, repeating
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'(16'h0030 + i), 16'h0, 1'b1, 16'(16'h0200 + i));
      chk("pattern_vid", vid_gnt, (i % 12) >= 8);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

    // Forced video grant, video drops after two burst grants
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 16'h0300);
    chk("burst_before_drop", vid_gnt, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h0300);
    chk("drop_no_cpu", cpu_gnt, 1'b0);
    chk("drop_no_vid", vid_gnt, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 16'h0300);
      chk("after_drop_vid", vid_gnt, i == 8);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

    // Reset pulsed mid-burst
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0, 1'b1, 16'h0400);
    chk("mid_burst_vid", vid_gnt, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_vid_gnt", vid_gnt, 1'b0);
    chk("async_cpu_gnt", cpu_gnt, 1'b0);
    model_reset();
    step(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0, 1'b1, 16'h0400);
    chk("abort_no_vrv", vid_rvalid, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0, 1'b1, 16'h0400);
      chk("post_reset_vid", vid_gnt, i == 8);
    end

    // Randomised traffic; requesters hold until granted, occasionally withdraw
    hcr = 1'b0; hcw = 1'b0; hvr = 1'b0; hca = '0; hcd = '0; hva = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(hcr && !last_gc) || $urandom_range(0, 15) == 0) begin
        hcr = $urandom_range(0, 2) != 0;
        hcw = 1'($urandom);
        hca = 16'($urandom);
        hcd = 16'($urandom);
      end
      if (!(hvr && !last_gv) || $urandom_range(0, 15) == 0) begin
        hvr = $urandom_range(0, 3) != 0;
        hva = 16'($urandom);
      end
      rst_r = $urandom_range(0, 149) != 0;
      step(rst_r, hcr, hcw, hca, hcd, hvr, hva);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
